// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters (CPU data side, loader/debug) and the
// shared data-memory port. The arbiter takes the slave view; whatever drives
// requests and models the memory takes the master view.
interface dmem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    // CPU data side
    logic          cpu_req;
    logic          cpu_we;
    logic          cpu_sb;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_gnt;
    logic          cpu_stall;
    logic          cpu_rvalid;
    logic [DW-1:0] cpu_rdata;

    // Loader / debug master
    logic          ldr_req;
    logic          ldr_lock;
    logic          ldr_we;
    logic          ldr_sb;
    logic [AW-1:0] ldr_addr;
    logic [DW-1:0] ldr_wdata;
    logic          ldr_gnt;
    logic          ldr_rvalid;
    logic [DW-1:0] ldr_rdata;

    // Data memory port
    logic          mem_we;
    logic          mem_sb;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_sb, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
        input  ldr_req, ldr_lock, ldr_we, ldr_sb, ldr_addr, ldr_wdata,
        output ldr_gnt, ldr_rvalid, ldr_rdata,
        output mem_we, mem_sb, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_sb, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
        output ldr_req, ldr_lock, ldr_we, ldr_sb, ldr_addr, ldr_wdata,
        input  ldr_gnt, ldr_rvalid, ldr_rdata,
        input  mem_we, mem_sb, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: CPU-first, with a starvation guarantee and a
// bounded locked burst for the loader. Grants and the memory mux are
// combinational; read data comes back one cycle later through per-requester
// registers.
module dmem_arbiter #(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = 3,
    parameter int BURST_MAX    = 4
) (
    input  logic            clk,
    input  logic            reset,   // asynchronous, active low
    dmem_arbiter_if.slave   bus
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int BW = $clog2(BURST_MAX + 1);
    // A one-beat "burst" is just a normal grant, so only lock when it can last.
    localparam bit CAN_LOCK = (BURST_MAX > 1);

    typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [BW-1:0] beat_q, beat_d;
    logic [BW-1:0] beat_nxt;

    logic          ldr_owed;
    logic          cpu_gnt, ldr_gnt;
    logic          mem_we, mem_sb;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;

    logic          cpu_rvalid_q, ldr_rvalid_q;
    logic [DW-1:0] cpu_rdata_q, ldr_rdata_q;

    assign beat_nxt = beat_q + BW'(1);

    // State and counter registers; reset abandons any burst in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            starve_q <= '0;
            beat_q   <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            beat_q   <= beat_d;
        end
    end

    // Next state: burst entry/continuation/exit and the loader starvation count.
    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        starve_d = starve_q;
        case (state_q)
            IDLE: begin
                if (ldr_gnt && bus.ldr_lock && CAN_LOCK) begin
                    state_d = BURST;
                    beat_d  = BW'(1);
                end
            end
            BURST: begin
                // Loader gone, lock dropped, or this beat was the last allowed.
                if (!ldr_gnt || !bus.ldr_lock || (beat_nxt >= BW'(BURST_MAX))) begin
                    state_d = IDLE;
                    beat_d  = '0;
                end else begin
                    beat_d  = beat_nxt;
                end
            end
            default: begin
                state_d = IDLE;
                beat_d  = '0;
            end
        endcase

        if (bus.ldr_req && cpu_gnt) begin
            if (starve_q != SW'(STARVE_LIMIT))
                starve_d = starve_q + SW'(1);
        end else if (ldr_gnt || !bus.ldr_req) begin
            starve_d = '0;
        end
    end

    // Outputs: grant priority and the memory-port mux; nothing granted in reset.
    always_comb begin
        ldr_owed  = bus.ldr_req && ((state_q == BURST) || (starve_q == SW'(STARVE_LIMIT)));
        cpu_gnt   = reset && bus.cpu_req && !ldr_owed;
        ldr_gnt   = reset && bus.ldr_req && (ldr_owed || !bus.cpu_req);
        mem_we    = 1'b0;
        mem_sb    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (cpu_gnt) begin
            mem_we    = bus.cpu_we;
            mem_sb    = bus.cpu_sb;
            mem_addr  = bus.cpu_addr;
            mem_wdata = bus.cpu_wdata;
        end else if (ldr_gnt) begin
            mem_we    = bus.ldr_we;
            mem_sb    = bus.ldr_sb;
            mem_addr  = bus.ldr_addr;
            mem_wdata = bus.ldr_wdata;
        end
    end

    // Read return: capture memory data at the edge that ends a granted read.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cpu_rvalid_q <= 1'b0;
            ldr_rvalid_q <= 1'b0;
            cpu_rdata_q  <= '0;
            ldr_rdata_q  <= '0;
        end else begin
            cpu_rvalid_q <= cpu_gnt && !bus.cpu_we;
            ldr_rvalid_q <= ldr_gnt && !bus.ldr_we;
            if (cpu_gnt && !bus.cpu_we) cpu_rdata_q <= bus.mem_rdata;
            if (ldr_gnt && !bus.ldr_we) ldr_rdata_q <= bus.mem_rdata;
        end
    end

    assign bus.cpu_gnt    = cpu_gnt;
    assign bus.ldr_gnt    = ldr_gnt;
    assign bus.cpu_stall  = bus.cpu_req & ~cpu_gnt;
    assign bus.mem_we     = mem_we;
    assign bus.mem_sb     = mem_sb;
    assign bus.mem_addr   = mem_addr;
    assign bus.mem_wdata  = mem_wdata;
    assign bus.cpu_rvalid = cpu_rvalid_q;
    assign bus.cpu_rdata  = cpu_rdata_q;
    assign bus.ldr_rvalid = ldr_rvalid_q;
    assign bus.ldr_rdata  = ldr_rdata_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a small word memory answers the port, a behavioural
// model (loss count, beats-in-burst, pending read returns) predicts every
// output each cycle, and directed scenarios check the documented sequences.
module tb_dmem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SL = 3;
    localparam int BM = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    dmem_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(SL), .BURST_MAX(BM)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Memory: combinational read, clocked write, byte store into addressed lane.
    logic [31:0] tbmem [64];
    assign bus.mem_rdata = tbmem[bus.mem_addr[7:2]];
    always @(posedge clk) begin
        if (bus.mem_we) begin
            if (bus.mem_sb)
                tbmem[bus.mem_addr[7:2]][bus.mem_addr[1:0]*8 +: 8] <= bus.mem_wdata[7:0];
            else
                tbmem[bus.mem_addr[7:2]] <= bus.mem_wdata;
        end
    end

    int checks = 0;
    int fails  = 0;

    // Reference model state
    int          m_starve, m_beats;
    logic        e_crv, e_lrv;
    logic [31:0] e_crd, e_lrd;

    // Last observed DUT values, for directed sequence checks
    logic        obs_cg, obs_lg, obs_st, obs_crv, obs_lrv, obs_we, obs_sb;
    logic [31:0] obs_crd, obs_lrd;

    logic [7:0]  stall_pat, lgnt_pat;
    logic [4:0]  we_pat, sb_pat;
    logic [31:0] pre;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic set_cpu(input logic req, input logic we, input logic sb,
                           input logic [31:0] addr, input logic [31:0] wd);
        bus.cpu_req = req; bus.cpu_we = we; bus.cpu_sb = sb;
        bus.cpu_addr = addr; bus.cpu_wdata = wd;
    endtask

    task automatic set_ldr(input logic req, input logic lock, input logic we, input logic sb,
                           input logic [31:0] addr, input logic [31:0] wd);
        bus.ldr_req = req; bus.ldr_lock = lock; bus.ldr_we = we; bus.ldr_sb = sb;
        bus.ldr_addr = addr; bus.ldr_wdata = wd;
    endtask

    task automatic model_reset();
        m_starve = 0; m_beats = 0;
        e_crv = 1'b0; e_lrv = 1'b0; e_crd = '0; e_lrd = '0;
    endtask

    // One clock cycle: called just after a falling edge with inputs applied.
    task automatic step();
        logic owed, gc, gl, ewe, esb;
        logic [31:0] ea, ew;
        #1;
        // Loader is owed the port while in a burst or after losing SL times.
        owed = bus.ldr_req && (m_beats > 0 || m_starve >= SL);
        gc = bus.cpu_req && !owed;
        gl = bus.ldr_req && (owed || !bus.cpu_req);
        ewe = 1'b0; esb = 1'b0; ea = '0; ew = '0;
        if (gc) begin
            ewe = bus.cpu_we; esb = bus.cpu_sb; ea = bus.cpu_addr; ew = bus.cpu_wdata;
        end else if (gl) begin
            ewe = bus.ldr_we; esb = bus.ldr_sb; ea = bus.ldr_addr; ew = bus.ldr_wdata;
        end
        chk1("cpu_gnt", bus.cpu_gnt, gc);
        chk1("ldr_gnt", bus.ldr_gnt, gl);
        chk1("cpu_stall", bus.cpu_stall, bus.cpu_req && !gc);
        chk1("mem_we", bus.mem_we, ewe);
        chk1("mem_sb", bus.mem_sb, esb);
        chk32("mem_addr", bus.mem_addr, ea);
        chk32("mem_wdata", bus.mem_wdata, ew);
        chk1("cpu_rvalid", bus.cpu_rvalid, e_crv);
        chk1("ldr_rvalid", bus.ldr_rvalid, e_lrv);
        chk32("cpu_rdata", bus.cpu_rdata, e_crd);
        chk32("ldr_rdata", bus.ldr_rdata, e_lrd);
        obs_cg = bus.cpu_gnt; obs_lg = bus.ldr_gnt; obs_st = bus.cpu_stall;
        obs_crv = bus.cpu_rvalid; obs_lrv = bus.ldr_rvalid;
        obs_crd = bus.cpu_rdata; obs_lrd = bus.ldr_rdata;
        obs_we = bus.mem_we; obs_sb = bus.mem_sb;
        // Predictions for the next cycle (memory contents before this edge's write)
        e_crv = gc && !bus.cpu_we;
        e_lrv = gl && !bus.ldr_we;
        if (e_crv) e_crd = tbmem[bus.cpu_addr[7:2]];
        if (e_lrv) e_lrd = tbmem[bus.ldr_addr[7:2]];
        if (gl) begin
            if (m_beats > 0) m_beats = (bus.ldr_lock && m_beats + 1 < BM) ? m_beats + 1 : 0;
            else             m_beats = (bus.ldr_lock && BM > 1) ? 1 : 0;
        end else begin
            m_beats = 0;
        end
        if (bus.ldr_req && gc)        m_starve = (m_starve < SL) ? m_starve + 1 : SL;
        else if (gl || !bus.ldr_req)  m_starve = 0;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) tbmem[i] <= 32'h0101_0101 * i ^ 32'h5A00_C300;
        model_reset();
        set_cpu(1'b1, 1'b1, 1'b0, 32'h44, 32'h1111_1111);
        set_ldr(1'b1, 1'b1, 1'b1, 1'b0, 32'h48, 32'h2222_2222);

        // Reset state: nothing granted, nothing written, returns cleared.
        #12;
        chk1("rst_cpu_gnt", bus.cpu_gnt, 1'b0);
        chk1("rst_ldr_gnt", bus.ldr_gnt, 1'b0);
        chk1("rst_mem_we", bus.mem_we, 1'b0);
        chk1("rst_cpu_rvalid", bus.cpu_rvalid, 1'b0);
        chk1("rst_ldr_rvalid", bus.ldr_rvalid, 1'b0);
        chk32("rst_cpu_rdata", bus.cpu_rdata, 32'h0);
        chk32("rst_ldr_rdata", bus.ldr_rdata, 32'h0);
        set_cpu(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_ldr(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        reset = 1'b1;

        // Idle: all memory outputs zero, no strobes.
        repeat (3) step();

        // CPU read of 0x40
        tbmem[16] <= 32'hDEAD_BEEF;
        set_cpu(1'b1, 1'b0, 1'b0, 32'h40, 32'h0);
        step();
        chk1("rd_gnt", obs_cg, 1'b1);
        set_cpu(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
        chk1("rd_rvalid", obs_crv, 1'b1);
        chk32("rd_rdata", obs_crd, 32'hDEAD_BEEF);
        chk1("rd_ldr_rvalid", obs_lrv, 1'b0);
        step();
        chk1("rd_rvalid_once", obs_crv, 1'b0);
        chk32("rd_rdata_hold", obs_crd, 32'hDEAD_BEEF);

        // Starvation: both held continuously
        set_cpu(1'b1, 1'b0, 1'b0, 32'h40, 32'h0);
        set_ldr(1'b1, 1'b0, 1'b0, 1'b0, 32'h80, 32'h0);
        for (int i = 0; i < 8; i++) begin
            step();
            stall_pat[i] = obs_st;
            lgnt_pat[i]  = obs_lg;
        end
        chk32("starve_stall_pat", 32'(stall_pat), 32'h88);
        chk32("starve_ldr_pat", 32'(lgnt_pat), 32'h88);

        // Locked burst once the loader has lost SL cycles
        repeat (3) step();
        set_ldr(1'b1, 1'b1, 1'b0, 1'b0, 32'h84, 32'h0);
        for (int i = 0; i < 6; i++) begin
            step();
            lgnt_pat[i] = obs_lg;
        end
        chk32("burst_ldr_pat", 32'(lgnt_pat[5:0]), 32'h0F);

        // Early unlock with a byte store in beat 2
        pre = tbmem[4];
        for (int i = 0; i < 5; i++) begin
            if (i == 2)      set_ldr(1'b1, 1'b1, 1'b1, 1'b1, 32'h10, 32'h0000_00AB);
            else if (i == 3) set_ldr(1'b1, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0);
            else if (i == 4) set_ldr(1'b1, 1'b0, 1'b0, 1'b0, 32'h20, 32'h0);
            else             set_ldr(1'b1, 1'b1, 1'b0, 1'b0, 32'h20, 32'h0);
            step();
            lgnt_pat[i] = obs_lg;
            we_pat[i]   = obs_we;
            sb_pat[i]   = obs_sb;
        end
        chk32("unlock_ldr_pat", 32'(lgnt_pat[4:0]), 32'h0E);
        chk32("unlock_we_pat", 32'(we_pat), 32'h04);
        chk32("unlock_sb_pat", 32'(sb_pat), 32'h04);
        chk32("unlock_readback", obs_lrd, {pre[31:8], 8'hAB});

        // Reset at beat 2 of a locked burst
        set_cpu(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_ldr(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
        set_cpu(1'b1, 1'b0, 1'b0, 32'h44, 32'h0);
        set_ldr(1'b1, 1'b1, 1'b0, 1'b0, 32'h2C, 32'h0);
        for (int i = 0; i < 10 && m_beats != 1; i++) step();
        chk1("mb_beat1_ldr", obs_lg, 1'b1);
        set_ldr(1'b1, 1'b1, 1'b1, 1'b0, 32'h30, 32'h1234_5678);
        pre = tbmem[12];
        #1;
        chk1("mb_beat2_ldr", bus.ldr_gnt, 1'b1);
        #1 reset = 1'b0;
        #1;
        chk1("mb_rst_cpu_gnt", bus.cpu_gnt, 1'b0);
        chk1("mb_rst_ldr_gnt", bus.ldr_gnt, 1'b0);
        chk1("mb_rst_mem_we", bus.mem_we, 1'b0);
        @(posedge clk);
        @(negedge clk);
        chk32("mb_no_write", tbmem[12], pre);
        model_reset();
        reset = 1'b1;
        set_ldr(1'b1, 1'b0, 1'b0, 1'b0, 32'h30, 32'h0);
        step();
        chk1("mb_cpu_first", obs_cg, 1'b1);

        // Randomized traffic; the CPU holds its request until granted.
        obs_st = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!obs_st)
                set_cpu($urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)),
                        $urandom_range(0, 3) == 0, 32'($urandom), 32'($urandom));
            set_ldr($urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0,
                    1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0,
                    32'($urandom), 32'($urandom));
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data-memory port between the MIPS core's data side and a loader/debug master that preloads and inspects memory.
- Sits between the processor's data interface and the data memory, which has a combinational read and a clocked write with byte-store support.
- Arbitration is CPU-first, with two exceptions:
  - a starvation guarantee for the loader;
  - a bounded locked burst for the loader.
- Read data is returned through a registered, one-cycle-latency return path per requester.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- STARVE_LIMIT, 3: number of consecutive cycles the loader may lose to the CPU before it is force-granted one cycle.
- BURST_MAX, 4: maximum beats in one locked loader burst.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU access request (held until granted).
- cpu_we  in  1  CPU write enable.
- cpu_sb  in  1  CPU store-byte qualifier.
- cpu_addr  in  AW  CPU address.
- cpu_wdata  in  DW  CPU write data.
- cpu_gnt  out  1  CPU owns memory this cycle (combinational).
- cpu_stall  out  1  cpu_req & ~cpu_gnt; freezes the pipeline.
- cpu_rvalid  out  1  registered read-return strobe.
- cpu_rdata  out  DW  registered read data.
- ldr_req  in  1  loader request.
- ldr_lock  in  1  request a locked burst.
- ldr_we  in  1  loader write enable.
- ldr_sb  in  1  loader store-byte qualifier.
- ldr_addr  in  AW  loader address.
- ldr_wdata  in  DW  loader write data.
- ldr_gnt  out  1  loader owns memory this cycle.
- ldr_rvalid  out  1  registered read-return strobe.
- ldr_rdata  out  DW  registered read data.
- mem_we  out  1  to dmem write enable.
- mem_sb  out  1  to dmem byte-store.
- mem_addr  out  AW  to dmem address.
- mem_wdata  out  DW  to dmem write data.
- mem_rdata  in  DW  from dmem, combinational read.

Behaviour:
- State machine: IDLE, BURST.
- Counters:
  - starve_cnt, 0..STARVE_LIMIT, saturating.
  - beat_cnt, 0..BURST_MAX.
- Reset (reset=0, async):
  - state=IDLE, starve_cnt=0, beat_cnt=0.
  - cpu_rvalid=ldr_rvalid=0, cpu_rdata=ldr_rdata=0.
  - Grants are 0 while reset is low.
  - A burst in progress is abandoned; no write may occur during reset.
- Grant priority, evaluated combinationally each cycle:
  1. State BURST and ldr_req=1: loader is granted.
  2. ldr_req=1 and starve_cnt==STARVE_LIMIT: loader is granted.
  3. cpu_req=1: CPU is granted.
  4. ldr_req=1: loader is granted.
  5. Otherwise no grant.
- Grants are mutually exclusive; at most one of cpu_gnt and ldr_gnt is high.
- Mux:
  - The granted requester's we/sb/addr/wdata drive mem_*.
  - With no grant: mem_we=0, mem_sb=0, mem_addr=0, mem_wdata=0.
- Access timing: the write commits at the rising edge that ends the grant cycle.
- Read return:
  - A granted read (we=0) captures mem_rdata into <req>_rdata at the edge ending the grant cycle.
  - <req>_rvalid is high for exactly the next cycle.
  - Writes never raise rvalid.
  - rdata holds its value when rvalid is low.
- starve_cnt:
  - Increments when ldr_req=1 and the CPU is granted.
  - Clears to 0 when the loader is granted or ldr_req=0.
  - Otherwise holds.
- Burst entry: in IDLE, loader granted with ldr_lock=1 → state=BURST next cycle, beat_cnt=1.
- Burst continuation: in BURST, loader granted → beat_cnt+1.
- Burst exit to IDLE (beat_cnt←0) at the edge where any of these holds:
  - beat_cnt+1 reached BURST_MAX on this beat;
  - ldr_lock=0 this beat;
  - ldr_req=0 in BURST. In that cycle the grant falls to the CPU per rule 3.
- Burst length: a burst is never longer than BURST_MAX beats. After a burst exit, the CPU wins the next cycle if it is requesting, because starve_cnt=0.
- Simultaneous events:
  - CPU and loader both requesting with starve_cnt<LIMIT and IDLE → CPU.
  - Starvation and lock in the same cycle → the loader enters BURST.
- cpu_stall is purely combinational and deasserts in the same cycle the grant arrives.

Test Plan:
- Reset mid-burst: assert reset low at beat 2 of a locked burst → grants drop immediately, state=IDLE. After release with both requesting, cpu_gnt=1.
- CPU read: cpu_req=1, cpu_we=0, addr=0x40, mem_rdata=0xDEADBEEF → cpu_gnt=1 in cycle 0. Next cycle cpu_rvalid=1 and cpu_rdata=0xDEADBEEF; ldr_rvalid stays 0.
- Starvation: both requesters held high continuously → the CPU is granted cycles 0-2, the loader cycle 3, the CPU cycles 4-6, the loader cycle 7. cpu_stall=1 exactly in cycles 3 and 7.
- Locked burst: ldr_lock=1 and ldr_req=1 for 6 cycles with cpu_req=1 and starve_cnt at LIMIT → the loader is granted 4 consecutive beats (BURST_MAX), then the CPU, then the loader resumes according to the starvation count.
- Early unlock: ldr_lock drops after beat 2 → state=IDLE at that edge and the CPU wins the next cycle. A loader byte store (ldr_sb=1, wdata=0x000000AB, addr=0x10) during the burst shows mem_sb=1 and mem_we=1 only in its beat.
- Idle: no requests → all mem_* outputs are 0, no rvalid strobes, starve_cnt remains 0.
